// File: rtl/mult_datapath.sv
// Add/subtract-and-shift datapath for an 8x8 signed multiplier: A, B and X registers.
// Define MULT_SHIFT_COUNT_EN to build the shift counter, Shift_Cnt and Done.
module mult_datapath (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] s_i,
    input  logic       clr_ld_i,
    input  logic       clear_a_i,
    input  logic       add_i,
    input  logic       sub_i,
    input  logic       shift_i,
    output logic [7:0] aval_o,
    output logic [7:0] bval_o,
    output logic       x_o,
    output logic       m_o,
    output logic [3:0] shift_cnt_o,
    output logic       done_o
);

    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       x_q, x_d;
    logic [8:0] sum;

    // Sub wins over Add, so the ALU only needs to know whether Sub is asserted.
    always_comb begin
        if (sub_i) begin
            sum = {a_q[7], a_q} - {s_i[7], s_i};
        end else begin
            sum = {a_q[7], a_q} + {s_i[7], s_i};
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (clr_ld_i) begin
            b_d = s_i;
            a_d = 8'h00;
            x_d = 1'b0;
        end else if (clear_a_i) begin
            a_d = 8'h00;
            x_d = 1'b0;
        end else if (sub_i || add_i) begin
            {x_d, a_d} = sum;
        end else if (shift_i) begin
            a_d = {x_q, a_q[7:1]};
            b_d = {a_q[0], b_q[7:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign aval_o = a_q;
    assign bval_o = b_q;
    assign x_o    = x_q;
    assign m_o    = b_q[0];

`ifdef MULT_SHIFT_COUNT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       shift_eff;

    assign shift_eff = shift_i & ~clr_ld_i & ~clear_a_i & ~add_i & ~sub_i;

    // Counter saturates at 8; Done fires only on the 7 -> 8 transition.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr_ld_i || clear_a_i) begin
            cnt_d = 4'd0;
        end else if (shift_eff && (cnt_q != 4'd8)) begin
            cnt_d  = cnt_q + 4'd1;
            done_d = (cnt_q == 4'd7);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign shift_cnt_o = cnt_q;
    assign done_o      = done_q;
`else
    assign shift_cnt_o = 4'h0;
    assign done_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: directed scenarios plus random commands against an arithmetic model.
module tb_mult_datapath;

`ifdef MULT_SHIFT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s = 8'h00;
    logic       clr_ld = 1'b0, clear_a = 1'b0, add = 1'b0, sub = 1'b0, shift = 1'b0;
    logic [7:0] aval, bval;
    logic       x, m, done;
    logic [3:0] shift_cnt;

    int vectors = 0;
    int miscompares = 0;
    int done_pulses = 0;
    bit cmp_en = 1'b0;

    mult_datapath dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .s_i         (s),
        .clr_ld_i    (clr_ld),
        .clear_a_i   (clear_a),
        .add_i       (add),
        .sub_i       (sub),
        .shift_i     (shift),
        .aval_o      (aval),
        .bval_o      (bval),
        .x_o         (x),
        .m_o         (m),
        .shift_cnt_o (shift_cnt),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Reference model: signed arithmetic on integers and a 17-bit arithmetic shift.
    logic [7:0] a_m, b_m;
    logic       x_m, done_m;
    int         cnt_m;

    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] v, input bit do_sub);
        int r;
        r = do_sub ? (int'($signed(a)) - int'($signed(v))) : (int'($signed(a)) + int'($signed(v)));
        return r[8:0];
    endfunction

    function automatic logic [16:0] ashr17(input logic [16:0] v);
        logic signed [16:0] t;
        t = v;
        return t >>> 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_m <= 8'h00; b_m <= 8'h00; x_m <= 1'b0; cnt_m <= 0; done_m <= 1'b0;
        end else begin
            done_m <= 1'b0;
            if (clr_ld) begin
                b_m <= s; a_m <= 8'h00; x_m <= 1'b0; cnt_m <= 0;
            end else if (clear_a) begin
                a_m <= 8'h00; x_m <= 1'b0; cnt_m <= 0;
            end else if (sub) begin
                {x_m, a_m} <= alu(a_m, s, 1'b1);
            end else if (add) begin
                {x_m, a_m} <= alu(a_m, s, 1'b0);
            end else if (shift) begin
                {x_m, a_m, b_m} <= ashr17({x_m, a_m, b_m});
                if (cnt_m < 8) cnt_m <= cnt_m + 1;
                if (cnt_m == 7) done_m <= 1'b1;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] cnt_exp;
        logic       done_exp;
        cnt_exp  = CNT_EN ? 4'(cnt_m) : 4'h0;
        done_exp = CNT_EN ? done_m : 1'b0;
        if (done) done_pulses++;
        if (cmp_en) begin
            vectors++;
            if (aval !== a_m || bval !== b_m || x !== x_m || m !== b_m[0] ||
                shift_cnt !== cnt_exp || done !== done_exp) begin
                miscompares++;
                $display("FAIL cycle t=%0t got A=%h B=%h X=%b M=%b cnt=%0d done=%b want A=%h B=%h X=%b M=%b cnt=%0d done=%b",
                         $time, aval, bval, x, m, shift_cnt, done,
                         a_m, b_m, x_m, b_m[0], cnt_exp, done_exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    // Drive one command, let the rising edge sample it, return at the next falling edge.
    task automatic cmd(input logic [7:0] sv, input logic c, input logic ca,
                       input logic ad, input logic sb, input logic sh);
        s = sv; clr_ld = c; clear_a = ca; add = ad; sub = sb; shift = sh;
        @(negedge clk);
        clr_ld = 1'b0; clear_a = 1'b0; add = 1'b0; sub = 1'b0; shift = 1'b0;
    endtask

    initial begin
        int pulses0;
        logic [7:0] bconst;
        bconst = 8'h07;

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset_A", {24'h0, aval}, 32'h00);
        check("reset_cnt", {28'h0, shift_cnt}, 32'h0);

        // Load
        cmd(8'h07, 1, 0, 0, 0, 0);
        check("load_B", {24'h0, bval}, 32'h07);
        check("load_A", {24'h0, aval}, 32'h00);
        check("load_M", {31'h0, m}, 32'h1);
        check("load_cnt", {28'h0, shift_cnt}, 32'h0);

        // Add then Sub
        cmd(8'hFD, 0, 0, 1, 0, 0);
        check("add_XA", {23'h0, x, aval}, 32'h1FD);
        cmd(8'h03, 0, 0, 0, 1, 0);
        check("sub_XA", {23'h0, x, aval}, 32'h1FA);

        // Full multiply 0x07 * 0xFD
        cmd(8'h07, 1, 0, 0, 0, 0);
        pulses0 = done_pulses;
        for (int i = 0; i < 8; i++) begin
            if (bconst[i]) cmd(8'hFD, 0, 0, (i < 7), (i == 7), 0);
            cmd(8'hFD, 0, 0, 0, 0, 1);
        end
        check("mult_AB", {16'h0, aval, bval}, 32'hFFEB);
        check("mult_cnt", {28'h0, shift_cnt}, CNT_EN ? 32'h8 : 32'h0);
        cmd(8'h00, 0, 0, 0, 0, 0);
        check("mult_done_pulses", 32'(done_pulses - pulses0), CNT_EN ? 32'd1 : 32'd0);

        // Priority
        cmd(8'h11, 1, 0, 1, 0, 1);
        check("prio_B", {24'h0, bval}, 32'h11);
        check("prio_A", {24'h0, aval}, 32'h00);
        check("prio_cnt", {28'h0, shift_cnt}, 32'h0);
        cmd(8'h05, 0, 0, 1, 1, 0);
        check("prio_addsub", {23'h0, x, aval}, 32'h1FB);

        // Saturation
        cmd(8'h00, 0, 1, 0, 0, 0);
        pulses0 = done_pulses;
        for (int i = 0; i < 10; i++) cmd(8'h00, 0, 0, 0, 0, 1);
        cmd(8'h00, 0, 0, 0, 0, 0);
        check("sat_cnt", {28'h0, shift_cnt}, CNT_EN ? 32'h8 : 32'h0);
        check("sat_done_pulses", 32'(done_pulses - pulses0), CNT_EN ? 32'd1 : 32'd0);

        // Asynchronous reset mid-cycle with A = 0x5A; commands during reset are ignored
        cmd(8'h00, 0, 1, 0, 0, 0);
        cmd(8'h5A, 0, 0, 1, 0, 0);
        check("pre_reset_A", {24'h0, aval}, 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_A", {24'h0, aval}, 32'h00);
        check("async_reset_B", {24'h0, bval}, 32'h00);
        check("async_reset_XM", {30'h0, x, m}, 32'h0);
        cmd(8'h33, 1, 0, 1, 0, 1);
        check("reset_ignores_cmd", {16'h0, aval, bval}, 32'h0);
        rst_n = 1'b1;

        // Random commands, with one mid-cycle reset pulse
        for (int i = 0; i < 400; i++) begin
            logic [7:0] sv;
            int r;
            sv = 8'($urandom);
            r = $urandom_range(0, 99);
            if (i == 200) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cmd(sv, r < 5, (r >= 5 && r < 10) || ($urandom_range(0, 19) == 0),
                (r >= 10 && r < 35), (r >= 30 && r < 45), (r >= 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 S  input  8  multiplicand / load value (two's complement).
REQ-005 Clr_Ld  input  1  load B from S; clear A and X.
REQ-006 Clear_A  input  1  clear A and X.
REQ-007 Add  input  1  X:A <= sext(A) + sext(S).
REQ-008 Sub  input  1  X:A <= sext(A) - sext(S).
REQ-009 Shift  input  1  arithmetic right shift of X:A:B.
REQ-010 Aval  output  8  A register.
REQ-011 Bval  output  8  B register.
REQ-012 X  output  1  sign-extension flip-flop.
REQ-013 M  output  1  B[0], fed back to the controller.
REQ-014 Shift_Cnt  output  4  shifts since last Clr_Ld/Clear_A.
REQ-015 Done  output  1  one-cycle pulse on the eighth shift.

Function
REQ-016 Command priority SHALL be: Clr_Ld > Clear_A > Sub > Add > Shift; only the highest asserted command takes effect in a cycle.
REQ-017 Clr_Ld: B <= S, A <= 0, X <= 0, counter <= 0, all in the same edge.
REQ-018 Clear_A: A <= 0, X <= 0, counter <= 0; B unchanged.
REQ-019 Add/Sub: 9-bit two's-complement result; bit 8 -> X, bits 7:0 -> A; B and counter unchanged; carry out of bit 8 discarded.
REQ-020 Shift: X unchanged, A <= {X, A[7:1]}, B <= {A[0], B[7:1]}, counter increments.
REQ-021 Counter SHALL saturate at 8; further shifts still shift data but do not change the counter.
REQ-022 Done SHALL be high for exactly the cycle after the edge on which the counter goes 7 -> 8; never re-asserted until counter is cleared.
REQ-023 M SHALL equal Bval[0] combinationally; all other outputs are registered.
REQ-024 No command asserted: all registers hold.
REQ-025 Latency: every command visible on outputs one cycle after the sampling edge.

Reset
REQ-026 Reset_n low SHALL immediately force A, B, X, counter, Done to 0 (M = 0), independent of Clk.
REQ-027 Reset mid-operation SHALL abandon the operation; first edge after Reset_n rises executes commands normally.
REQ-028 Commands sampled while Reset_n is low SHALL be ignored.

Configuration
REQ-029 Macro MULT_SHIFT_COUNT_EN defined: shift counter, Shift_Cnt, and Done implemented per REQ-020..022.
REQ-030 Macro MULT_SHIFT_COUNT_EN undefined: no counter logic; Shift_Cnt tied 4'h0, Done tied 0; ports remain present; all data behaviour identical.

Verification
REQ-031 Reset: assert Reset_n=0 mid-cycle with A=0x5A -> Aval=0x00, Bval=0x00, X=0, M=0 before next edge.
REQ-032 Load: S=0x07, Clr_Ld 1 cycle -> Bval=0x07, Aval=0x00, X=0, M=1, Shift_Cnt=0.
REQ-033 Add/Sub: A=0x00, S=0xFD, Add -> X=1, Aval=0xFD; then S=0x03, Sub -> X=1, Aval=0xFA.
REQ-034 Full multiply: load B=0x07, S=0xFD, sequence Add/Shift per M for 7 bits, Sub on 8th bit if M=1, Shift -> {Aval,Bval}=0xFFEB (-21), Done pulses once, Shift_Cnt=8.
REQ-035 Priority: Clr_Ld, Add, Shift together with S=0x11 -> Bval=0x11, Aval=0x00, Shift_Cnt=0; Add+Sub together -> Sub result.
REQ-036 Saturation: 10 consecutive shifts after Clear_A -> Shift_Cnt=8, Done high exactly one cycle; with macro undefined Shift_Cnt=0, Done=0 throughout.
